// File: rtl/definitions_pkg.sv
// Shared definitions for the ALU execute stage.
//   alu_sel_e : 4-bit ALU operation select produced by the ALU control decoder.
//   DEF_XLEN  : default operand/result width.
//   DEF_CNT_W : default retired-operation counter width.
package definitions_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_CNT_W = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_sel_e;

    function automatic logic is_mapped_sel(input alu_sel_e sel);
        case (sel)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB: is_mapped_sel = 1'b1;
            default:                           is_mapped_sel = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Handshake bundle of the ALU execute stage.
//   in_*  : operand/opcode transfer from decode (valid/ready).
//   out_* : registered result towards writeback (valid/ready).
// master : upstream/downstream environment side.
// slave  : the execute stage itself.
interface alu_exec_stage_if
    import definitions_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    alu_sel_e        in_sel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic            out_illegal;

    modport master (
        output in_valid, in_a, in_b, in_sel, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_illegal
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_illegal
    );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath.
//   a, b    : operands
//   sel     : operation select
//   result  : a op b modulo 2^XLEN, or 0 for an unmapped select
//   zero    : result == 0
//   illegal : sel is not a mapped encoding
module alu_core
    import definitions_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_sel_e        sel,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        // Unknown/unmapped selects fall to default: result 0, flagged illegal.
        case (sel)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: accepts operands + opcode over valid/ready, computes the
// result through alu_core and holds it in one output register with backpressure.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : in_* operand handshake, out_* result handshake (slave side)
//   err_clr     : synchronous clear of err_sticky
//   err_sticky  : set when an illegal opcode was accepted
//   ops_retired : count of results consumed downstream (wraps)
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | output register empty, out_valid = 0
// ST_FULL  | output register holds a result, out_valid = 1
module alu_exec_stage
    import definitions_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_exec_stage_if.slave      bus,
    input  logic                 err_clr,
    output logic                 err_sticky,
    output logic [CNT_W-1:0]     ops_retired
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic             state_q, state_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  core_result;
    logic             core_zero;
    logic             core_illegal;
    logic             accept;
    logic             consume;

    alu_core #(.XLEN(XLEN)) u_core (
        .a       (bus.in_a),
        .b       (bus.in_b),
        .sel     (bus.in_sel),
        .result  (core_result),
        .zero    (core_zero),
        .illegal (core_illegal)
    );

    // Ready whenever the register is empty or is being drained this cycle,
    // which allows one result per cycle under continuous out_ready.
    assign bus.in_ready = (state_q == ST_EMPTY) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign consume      = (state_q == ST_FULL) && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        err_d     = err_q;
        cnt_d     = cnt_q;

        if (state_q == ST_EMPTY) begin
            if (accept) state_d = ST_FULL;
        end else begin
            if (consume && !accept) state_d = ST_EMPTY;
        end

        if (accept) begin
            result_d  = core_result;
            zero_d    = core_zero;
            illegal_d = core_illegal;
        end

        // Set has priority over clear.
        if (accept && core_illegal) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end

        if (consume) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.out_valid   = (state_q == ST_FULL);
    assign bus.out_result  = result_q;
    assign bus.out_zero    = zero_q;
    assign bus.out_illegal = illegal_q;
    assign err_sticky      = err_q;
    assign ops_retired     = cnt_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;
    import definitions_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic err_clr;
    logic err_sticky;
    logic [31:0] ops_retired;
    logic err_clr_w;
    logic err_sticky_w;
    logic [3:0] ops_retired_w;

    alu_exec_stage_if #(.XLEN(32)) bus ();
    alu_exec_stage_if #(.XLEN(32)) bus_w ();

    alu_exec_stage dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .err_clr     (err_clr),
        .err_sticky  (err_sticky),
        .ops_retired (ops_retired)
    );

    alu_exec_stage #(.CNT_W(4)) dut_w (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_w),
        .err_clr     (err_clr_w),
        .err_sticky  (err_sticky_w),
        .ops_retired (ops_retired_w)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        alu_sel_e    sel;
        logic [31:0] res;
        logic        zero;
        logic        illegal;
    } vec_t;

    vec_t vecs[7];
    logic [31:0] exp_cnt;
    logic [31:0] held;

    initial begin
        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, ALU_ADD, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0005, 32'h0000_0007, ALU_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND, 32'hF000_F000, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0001, 32'h0000_0002, ALU_OR,  32'h0000_0003, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, ALU_SUB, 32'h7FFF_FFFF, 1'b0, 1'b0};
        vecs[5] = '{32'h1234_5678, 32'h1111_1111, ALU_ADD, 32'h2345_6789, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0005, 32'h0000_0006, alu_sel_e'(4'b0011), 32'h0000_0000, 1'b1, 1'b1};

        rst = 1'b1;
        err_clr = 1'b0;
        err_clr_w = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sel = ALU_AND; bus.out_ready = 1'b0;
        bus_w.in_valid = 1'b0; bus_w.in_a = '0; bus_w.in_b = '0; bus_w.in_sel = ALU_AND; bus_w.out_ready = 1'b0;

        // Reset then idle
        #3;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_flags", {bus.out_zero, bus.out_illegal, err_sticky}, 0);
        check("rst_ops_retired", ops_retired, 0);
        @(negedge clk); rst = 1'b0;
        #1 check("idle_in_ready", bus.in_ready, 1);
        repeat (10) @(negedge clk);
        check("idle_out_valid", bus.out_valid, 0);
        check("idle_ops_retired", ops_retired, 0);

        // Table-driven ops, each with a drain cycle afterwards
        exp_cnt = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("vec%0d_in_ready", i), bus.in_ready, 1);
            bus.in_valid = 1'b1; bus.in_a = vecs[i].a; bus.in_b = vecs[i].b; bus.in_sel = vecs[i].sel;
            @(negedge clk);
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_out_valid", i), bus.out_valid, 1);
            check($sformatf("vec%0d_result", i), bus.out_result, vecs[i].res);
            check($sformatf("vec%0d_zero", i), bus.out_zero, vecs[i].zero);
            check($sformatf("vec%0d_illegal", i), bus.out_illegal, vecs[i].illegal);
            @(negedge clk);
            exp_cnt++;
            check($sformatf("vec%0d_drained", i), bus.out_valid, 0);
            check($sformatf("vec%0d_ops_retired", i), ops_retired, exp_cnt);
        end

        // Payload must not load while in_valid=0
        held = bus.out_result;
        bus.in_a = 32'hDEAD_BEEF; bus.in_b = 32'h1; bus.in_sel = ALU_ADD;
        @(negedge clk);
        check("idle_payload_hold", bus.out_result, held);
        check("idle_no_valid", bus.out_valid, 0);

        // Backpressure: ADD 2+3 held for 3 cycles, a second request waits
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 32'd2; bus.in_b = 32'd3; bus.in_sel = ALU_ADD;
        @(negedge clk);
        bus.in_a = 32'd10; bus.in_b = 32'd10;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d_out_valid", k), bus.out_valid, 1);
            check($sformatf("bp%0d_result", k), bus.out_result, 5);
            check($sformatf("bp%0d_in_ready", k), bus.in_ready, 0);
            @(negedge clk);
        end
        check("bp_ops_hold", ops_retired, exp_cnt);
        bus.out_ready = 1'b1;
        #1 check("bp_release_in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        exp_cnt++;
        check("bp_ops_retired", ops_retired, exp_cnt);
        check("bp_no_bubble_valid", bus.out_valid, 1);
        check("bp_no_bubble_result", bus.out_result, 20);
        @(negedge clk);
        exp_cnt++;
        check("bp_drain_valid", bus.out_valid, 0);
        check("bp_drain_ops", ops_retired, exp_cnt);

        // Back-to-back streaming of 8 after a fresh reset
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                check($sformatf("stream%0d_valid", k - 1), bus.out_valid, 1);
                check($sformatf("stream%0d_result", k - 1), bus.out_result, 32'(k - 1) * 3 + 100);
            end
            check($sformatf("stream%0d_in_ready", k), bus.in_ready, 1);
            if (k < 8) begin
                bus.in_valid = 1'b1; bus.in_a = 32'(k) * 3; bus.in_b = 32'd100; bus.in_sel = ALU_ADD;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("stream_drained", bus.out_valid, 0);
        check("stream_ops_retired", ops_retired, 8);

        // Illegal opcode and err_sticky set/clear priority
        check("err_before", err_sticky, 0);
        bus.in_valid = 1'b1; bus.in_a = 32'h55; bus.in_b = 32'h66; bus.in_sel = alu_sel_e'(4'b1111);
        @(negedge clk);
        check("ill_result", bus.out_result, 0);
        check("ill_flags", {bus.out_valid, bus.out_zero, bus.out_illegal}, 3'b111);
        check("ill_err_set", err_sticky, 1);
        err_clr = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("ill_set_wins", err_sticky, 1);
        check("ill_second_valid", bus.out_valid, 1);
        @(negedge clk);
        err_clr = 1'b0;
        check("ill_err_cleared", err_sticky, 0);
        check("ill_ops_retired", ops_retired, 10);

        // Async reset during a hold
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 32'd1; bus.in_b = 32'd1; bus.in_sel = ALU_ADD;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("arst_pre_valid", bus.out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_ops_retired", ops_retired, 0);
        check("arst_result", bus.out_result, 0);
        @(negedge clk); rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("arst_after_ops", ops_retired, 0);

        // Counter wrap on the CNT_W=4 instance: 17 retirements -> 1
        bus_w.out_ready = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            if (k == 16) check("wrap_at_15", ops_retired_w, 15);
            if (k == 17) check("wrap_at_16", ops_retired_w, 0);
            if (k < 17) begin
                bus_w.in_valid = 1'b1; bus_w.in_a = 32'(k); bus_w.in_b = 32'd1; bus_w.in_sel = ALU_OR;
            end else begin
                bus_w.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("wrap_final", ops_retired_w, 1);
        check("wrap_drained", bus_w.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
